// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a bank of common-anode 7-segment
// digits. The digits are visited in turn from 0 to NUM_DIGITS-1. Each visit has
// an all-dark BLANK phase that suppresses ghosting, followed by a SHOW phase
// that drives one digit. New frame data arrives over a valid/ready handshake.
// While scanning, that data is held in a staging register and is only moved to
// the display register at a frame boundary, so a frame never shows a mix of
// old and new digits.
//
// Parameters:
//   NUM_DIGITS - number of multiplexed digits (1..8)
//   DWELL      - clock cycles each digit is driven (>= 1)
//   BLANK      - dark cycles before each digit (0 removes the blank phase)
//
// Ports:
//   clock      - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   enable     - 1 = scan running, 0 = display dark
//   wr_valid   - new frame data offered
//   wr_ready   - block can accept wr_data
//   wr_data    - hex nibbles, bits [4i+3:4i] belong to digit i
//   seg_n      - segments a..g on bits 0..6, active-low
//   dig_n      - digit enables, active-low, at most one low
//   frame_done - one-cycle pulse in the last SHOW cycle of each frame
//
// Optional feature:
//   SEG_SCAN_LZB_EN - leading-zero blanking. When this is defined, digit i>0
//                     stays dark during its SHOW phase if nibbles
//                     i..NUM_DIGITS-1 are all zero.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 250,
    parameter int BLANK      = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     dig_n,
    output logic                      frame_done
);

    // One counter serves both phases, so it must reach the larger of the two
    // phase lengths minus one.
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   display_q, display_d;
    logic [4*NUM_DIGITS-1:0]   staging_q, staging_d;
    logic                      pending_q, pending_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     dig_q, dig_d;
    logic                      ready_q, ready_d;
    logic                      done_q, done_d;

    logic [3:0]                nibble;
    logic                      showOn;
`ifdef SEG_SCAN_LZB_EN
    logic                      upperZero;
`endif

    function automatic logic [6:0] hexToSeg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan sequencer. Dropping enable returns to IDLE from any state, so
    // re-enabling always restarts the scan cleanly at digit 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (BLANK > 0) ? ST_BLANK : ST_SHOW;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        state_d = (BLANK > 0) ? ST_BLANK : ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Frame data path. While the scan runs, new data waits in staging and
    // moves across only in a frame_done cycle whose pending flag was already
    // set. A write that lands in that cycle therefore waits a whole frame.
    // While dark there is nothing to tear, so data goes straight to the
    // display register. Any leftover pending word is flushed there as well.
    always_comb begin
        staging_d = staging_q;
        pending_d = pending_q;
        display_d = display_q;
        if (!enable) begin
            if (pending_q) begin
                display_d = staging_q;
                pending_d = 1'b0;
            end else if (wr_valid && ready_q) begin
                display_d = wr_data;
            end
        end else begin
            if (done_q && pending_q) begin
                display_d = staging_q;
                pending_d = 1'b0;
            end else if (wr_valid && ready_q) begin
                staging_d = wr_data;
                pending_d = 1'b1;
            end
        end
    end

    // Output registers are loaded from next-state values. The pins therefore
    // track the current state without any combinational path from the inputs.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble = display_d[4*i +: 4];
            end
        end
        showOn = (state_d == ST_SHOW);
`ifdef SEG_SCAN_LZB_EN
        upperZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_d) && (display_d[4*i +: 4] != 4'h0)) begin
                upperZero = 1'b0;
            end
        end
        if ((idx_d != '0) && upperZero) begin
            showOn = 1'b0;
        end
`endif
        seg_d = showOn ? hexToSeg(nibble) : 7'h7F;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_d[i] = !(showOn && (idx_d == IDX_W'(i)));
        end
        done_d  = (state_d == ST_SHOW) && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
        ready_d = !pending_d;
    end

    // State and output registers, all cleared asynchronously to the dark display.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            display_q <= '0;
            staging_q <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'h7F;
            dig_q     <= '1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            display_q <= display_d;
            staging_q <= staging_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign seg_n      = seg_q;
    assign dig_n      = dig_q;
    assign wr_ready   = ready_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=3, BLANK=1, so
// one frame is 16 cycles. A table of cycle-run records covers the first two
// frames, including a mid-frame write. Hand sequences then cover a write in
// the frame_done cycle, enable drop and re-enable, flushing of pending data
// when enable drops, and an asynchronous reset with data pending. The
// leading-zero blanking section is compiled only when SEG_SCAN_LZB_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .DWELL      (3),
        .BLANK      (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] data;
        int          n;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        fd;
        logic        rdy;
    } vec_t;

    vec_t vecs[19];

    // Inputs are driven at the falling edge and sampled by the DUT at the next
    // rising edge. The outputs are read at the falling edge after that.
    task automatic applyStimulus(input logic en, input logic valid, input logic [15:0] data);
        enable   = en;
        wr_valid = valid;
        wr_data  = data;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [6:0] eSeg, input logic [3:0] eDig,
                               input logic eFd, input logic eRdy);
        checks++;
        if (seg_n !== eSeg || dig_n !== eDig || frame_done !== eFd || wr_ready !== eRdy) begin
            errors++;
            $display("[TB] FAIL %s: got seg_n=%h dig_n=%h frame_done=%b wr_ready=%b, expected seg_n=%h dig_n=%h frame_done=%b wr_ready=%b",
                     name, seg_n, dig_n, frame_done, wr_ready, eSeg, eDig, eFd, eRdy);
        end
    endtask

    initial begin
        // First two frames after reset with enable held high. Frame 1 shows
        // zeros, and 16'h1234 is written during digit 1 of that frame.
        // Frame 2 shows 4,3,2,1 on digits 0..3.
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 3, 7'h40, 4'hE, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 16'h1234, 1, 7'h40, 4'hD, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 2, 7'h40, 4'hD, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 3, 7'h40, 4'hB, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 2, 7'h40, 4'h7, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1, 7'h40, 4'h7, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 3, 7'h19, 4'hE, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 3, 7'h30, 4'hD, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 3, 7'h24, 4'hB, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1, 7'h7F, 4'hF, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 16'h0000, 2, 7'h79, 4'h7, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1, 7'h79, 4'h7, 1'b1, 1'b1};

        reset_n  = 1'b0;
        enable   = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        repeat (3) @(negedge clock);
        checkOutput("reset", 7'h7F, 4'hF, 1'b0, 1'b1);
        reset_n = 1'b1;

        foreach (vecs[r]) begin
            for (int k = 0; k < vecs[r].n; k++) begin
                applyStimulus(vecs[r].en, vecs[r].valid, vecs[r].data);
                checkOutput($sformatf("vec%0d.%0d", r, k), vecs[r].seg, vecs[r].dig, vecs[r].fd, vecs[r].rdy);
            end
        end

        // A write in the frame_done cycle stays pending for one whole frame.
        applyStimulus(1'b1, 1'b1, 16'h5678);
        checkOutput("fdwr_blank", 7'h7F, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("fdwr_old_d0", 7'h19, 4'hE, 1'b0, 1'b0);
        repeat (14) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("fdwr_old_d3", 7'h79, 4'h7, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("fdwr_load", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("fdwr_new_d0", 7'h00, 4'hE, 1'b0, 1'b1);

        // Drop enable during digit 2, write while dark, then re-enable.
        repeat (8) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("dis_d2", 7'h02, 4'hB, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("dis_dark", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hABCD);
        checkOutput("dis_write", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("dis_idle", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("reen_blank", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("reen_d0", 7'h21, 4'hE, 1'b0, 1'b1);

        // Pending data is flushed to the display when enable drops.
        applyStimulus(1'b1, 1'b1, 16'h0042);
        checkOutput("flush_wr", 7'h21, 4'hE, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("flush_dark", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("flush_blank", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("flush_d0", 7'h24, 4'hE, 1'b0, 1'b1);

        // Asynchronous reset mid-SHOW with a write pending.
        applyStimulus(1'b1, 1'b1, 16'h9999);
        checkOutput("rst_pend", 7'h24, 4'hE, 1'b0, 1'b0);
        wr_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async", 7'h7F, 4'hF, 1'b0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rst_blank", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rst_d0_zero", 7'h40, 4'hE, 1'b0, 1'b1);

`ifdef SEG_SCAN_LZB_EN
        // Leading-zero blanking with 16'h0050: digits 3 and 2 stay dark.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0050);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("lzb_blank", 7'h7F, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("lzb_d0", 7'h40, 4'hE, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("lzb_d1", 7'h12, 4'hD, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("lzb_d2", 7'h7F, 4'hF, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("lzb_d3", 7'h7F, 4'hF, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DWELL, default 250: clock cycles each digit is driven; SHALL be >= 1.
REQ-003 Parameter BLANK, default 4: all-off cycles before each digit (anti-ghosting); 0 SHALL remove the blank phase.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  1 = scan running, 0 = display dark.
REQ-007 wr_valid  in  1  new frame data offered.
REQ-008 wr_ready  out  1  block can accept wr_data.
REQ-009 wr_data  in  4*NUM_DIGITS  hex nibbles; bits [4i+3:4i] = digit i; digit 0 least significant.
REQ-010 seg_n  out  7  segments a..g on bits 0..6, active-low.
REQ-011 dig_n  out  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-012 frame_done  out  1  one-cycle pulse at end of each full scan.

Function
REQ-013 States: IDLE, BLANK, SHOW; digit index idx, dwell counter cnt; counter widths SHALL be ceil(log2) of their maximum and never overflow.
REQ-014 IDLE -> BLANK (idx=0) when enable=1; if BLANK=0, IDLE -> SHOW directly.
REQ-015 BLANK lasts exactly BLANK cycles, then SHOW; dig_n all ones, seg_n=7'h7F throughout.
REQ-016 SHOW lasts exactly DWELL cycles with dig_n[idx]=0 and seg_n = hex decode of display nibble idx.
REQ-017 Decode, seg_n hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-018 End of SHOW: idx increments to next BLANK/SHOW; at idx=NUM_DIGITS-1 it wraps to 0 and frame_done pulses during that last SHOW cycle.
REQ-019 Frame length SHALL be NUM_DIGITS*(BLANK+DWELL) cycles.
REQ-020 Handshake: transfer when wr_valid & wr_ready; wr_data captured into staging register, pending set, wr_ready=0 next cycle.
REQ-021 While enable=1, display register SHALL load from staging only on frame_done cycle when pending was already set before that cycle; pending clears, wr_ready=1 next cycle; no tearing mid-frame.
REQ-022 Transfer in the frame_done cycle SHALL stay pending until the following frame_done.
REQ-023 While enable=0, transfer SHALL update display register the next cycle; wr_ready stays 1.
REQ-024 enable falling in any state: next cycle IDLE, outputs dark, idx=0, cnt=0; pending data SHALL then load into display the next cycle.
REQ-025 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, idx=0, cnt=0, display and staging=0, pending=0, seg_n=7'h7F, dig_n all ones, wr_ready=1, frame_done=0.
REQ-027 Reset mid-frame SHALL abandon the frame and discard pending data; scan restarts at digit 0 after release.

Configuration
REQ-028 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking -- during SHOW of digit i>0, if nibbles i..NUM_DIGITS-1 are all 0, dig_n stays all ones; timing, idx and frame_done unchanged; digit 0 always shown.
REQ-029 SEG_SCAN_LZB_EN undefined: every digit shown, including zeros; no blanking logic present.

Verification (NUM_DIGITS=4, DWELL=3, BLANK=1)
REQ-030 Reset, enable=1 -> 1 dark cycle, then dig_n=4'b1110, seg_n=7'h40 for 3 cycles; frame_done every 16 cycles.
REQ-031 Write 16'h1234 mid-frame -> wr_ready=0 next cycle; zeros shown until frame_done; next frame digit0 seg_n=7'h19, digit3 seg_n=7'h79; wr_ready=1.
REQ-032 Write coincident with frame_done -> display unchanged for one more frame, updates at next frame_done.
REQ-033 enable=0 during digit 2 SHOW -> next cycle dig_n=4'hF, seg_n=7'h7F; write 16'hABCD accepted, wr_ready stays 1; re-enable -> digit0 seg_n=7'h21.
REQ-034 reset_n low mid-SHOW with data pending -> outputs dark asynchronously; after release display=0, wr_ready=1.
REQ-035 With SEG_SCAN_LZB_EN, data 16'h0050 -> digits 3,2 dark (dig_n=4'hF in their SHOW), digit1 seg_n=7'h12, digit0 seg_n=7'h40.
